// File: rtl/dwt_mul_pkg.sv
// Shared definitions for the DWT multiplier arbiter.
// Holds operand / product / id widths and the controller state encoding.
package dwt_mul_pkg;

    localparam int A_W  = 11;   // operand a width (unsigned)
    localparam int B_W  = 9;    // operand b width (unsigned)
    localparam int P_W  = 20;   // product width, holds 2047*511 without truncation
    localparam int ID_W = 3;    // requester id width (up to 8 requesters)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/dwt_rr_arb.sv
// Round-robin grant logic for the shared multiplier.
//
// Optional feature: define DWT_MUL_ARB_PRIO0_EN to give requester 0 absolute
// priority; the remaining requesters then rotate among themselves.
//
// Ports:
//   clk, rst_n : clock and (already synchronised) async active-low reset
//   en         : grants permitted this cycle
//   req        : per-requester valid
//   gnt        : one-hot (or zero) grant, combinational from req and pointer
//   gnt_idx    : binary index of the granted requester (0 when no grant)
module dwt_rr_arb
    import dwt_mul_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic          adv;
    int            best;

    // Distance of requester i from the pointer in search order.
    function automatic int rank_of(input int i, input int p);
        return (i >= p) ? (i - p) : (i + N_REQ - p);
    endfunction

    // Two passes: find the closest active requester, then grant exactly it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        best    = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (en && req[i] && (rank_of(i, int'(ptr)) < best)) begin
                best = rank_of(i, int'(ptr));
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (en && req[i] && (rank_of(i, int'(ptr)) == best)) begin
                gnt[i]  = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
`ifdef DWT_MUL_ARB_PRIO0_EN
        if (en && req[0]) begin
            gnt     = '0;
            gnt[0]  = 1'b1;
            gnt_idx = '0;
        end
`endif
    end

    // Priority grants to requester 0 do not disturb the rotation of the rest.
`ifdef DWT_MUL_ARB_PRIO0_EN
    assign adv = (|gnt) && !gnt[0];
`else
    assign adv = |gnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : PW'(int'(gnt_idx) + 1);
        end
    end

endmodule

// File: rtl/dwt_mul_arbiter.sv
// Shares one 11x9 unsigned multiplier between N_REQ requesters.
//
// Optional feature macro: DWT_MUL_ARB_PRIO0_EN (requester 0 always wins).
//
// Ports:
//   ap_clk, ap_rst_n : clock, async active-low reset (deassertion synchronised)
//   run_en           : level; high permits new grants
//   req_valid        : per-requester operand valid
//   req_ready        : per-requester grant, one-hot or zero
//   req_a, req_b     : packed operands, requester i at [11i+10:11i] / [9i+8:9i]
//   rsp_valid        : product valid, PIPE_DEPTH cycles after the transfer cycle
//   rsp_id, rsp_p    : owner id and product; held while rsp_valid is low
//   idle             : controller in IDLE with the pipeline empty
//   dbg_state        : controller state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a transfer happens in a cycle where req_valid[i] and req_ready[i]
// are both high; req_ready only rises for a requester whose req_valid is high.
// There is no response back-pressure.
module dwt_mul_arbiter
    import dwt_mul_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 run_en,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [P_W-1:0]       rsp_p,
    output logic                 idle,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN   = 2'(ST_RUN);
    localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);

    // Reset asserts immediately, releases two ap_clk edges later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  grant_en;
    logic                  xfer;
    logic [ID_W-1:0]       gnt_idx;
    logic [A_W-1:0]        a_sel;
    logic [B_W-1:0]        b_sel;
    logic [P_W-1:0]        prod;
    logic [PIPE_DEPTH-1:0] vld;
    logic [PIPE_DEPTH-1:0] vld_shift;
    logic [P_W-1:0]        p_q  [PIPE_DEPTH];
    logic [ID_W-1:0]       id_q [PIPE_DEPTH];

    // run_en low in RUN already stops grants in the cycle it drops.
    assign grant_en = (state == S_RUN) && run_en;

    dwt_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (ap_clk),
        .rst_n   (rst_n),
        .en      (grant_en),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign xfer = |req_ready;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                a_sel = req_a[i*A_W +: A_W];
                b_sel = req_b[i*B_W +: B_W];
            end
        end
    end

    assign prod = P_W'(a_sel) * P_W'(b_sel);

    // Stage valids as they will be after the coming edge.
    always_comb begin
        vld_shift    = vld << 1;
        vld_shift[0] = xfer;
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                p_q[i]  <= '0;
                id_q[i] <= '0;
            end
        end else begin
            vld <= vld_shift;
            // Data registers load only with valid data so the last stage
            // holds the previous product while rsp_valid is low.
            if (xfer) begin
                p_q[0]  <= prod;
                id_q[0] <= gnt_idx;
            end
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (vld[i-1]) begin
                    p_q[i]  <= p_q[i-1];
                    id_q[i] <= id_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = vld[PIPE_DEPTH-1];
    assign rsp_p     = p_q[PIPE_DEPTH-1];
    assign rsp_id    = id_q[PIPE_DEPTH-1];

    // DRAIN leaves as soon as the last product is on the output, so idle
    // rises in the cycle right after the final rsp_valid.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run_en) state_nxt = S_RUN;
            S_RUN:   if (!run_en) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (run_en) begin
                    state_nxt = S_RUN;
                end else if (vld_shift == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign idle      = (state == S_IDLE) && (vld == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_dwt_mul_arbiter.sv
// Self-checking bench for dwt_mul_arbiter (N_REQ=4, PIPE_DEPTH=2).
// A reference model predicts grants and pushes expected products into a
// queue; a monitor pops and compares whenever the DUT presents rsp_valid.
module tb_dwt_mul_arbiter;

    localparam int N = 4;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           ap_rst_n = 1'b0;
    logic           run_en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*11-1:0] req_a = '0;
    logic [N*9-1:0] req_b = '0;
    logic           rsp_valid;
    logic [2:0]     rsp_id;
    logic [19:0]    rsp_p;
    logic           idle;
    logic [1:0]     dbg_state;

    dwt_mul_arbiter #(
        .N_REQ      (N),
        .PIPE_DEPTH (D)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (ap_rst_n),
        .run_en    (run_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .idle      (idle),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ptr_m = 0;
    bit          re1 = 1'b0;   // run_en one cycle ago
    bit          re2 = 1'b0;   // run_en two cycles ago
    bit          exp_idle = 1'b1;
    logic [54:0] exp_q[$];     // {due cycle[31:0], id[2:0], product[19:0]}
    logic [N-1:0] took = '0;
    logic [19:0] last_p = '0;
    logic [2:0]  last_id = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Grants are allowed in cycle c exactly when run_en is high now and was
    // high in cycle c-1. The winner is the first valid requester at or after
    // the pointer; the pointer moves just past the winner.
    int          sel;
    logic [N-1:0] eg;
    int          ma;
    int          mb;

    always @(negedge clk) begin
        cyc++;
        took = req_valid & req_ready;
        if (!ap_rst_n) begin
            exp_q.delete();
            ptr_m    = 0;
            re1      = 1'b0;
            re2      = 1'b0;
            exp_idle = 1'b1;
            chk("rst_ready", 64'(req_ready), 64'(0));
        end else begin
            exp_idle = !re1 && !re2 && (exp_q.size() == 0);
            eg  = '0;
            sel = -1;
            if (run_en && re1) begin
`ifdef DWT_MUL_ARB_PRIO0_EN
                if (req_valid[0]) sel = 0;
`endif
                for (int k = 0; k < N; k++) begin
                    if (sel < 0 && req_valid[(ptr_m + k) % N]) sel = (ptr_m + k) % N;
                end
            end
            if (sel >= 0) begin
                eg[sel] = 1'b1;
                ma = int'(req_a[sel*11 +: 11]);
                mb = int'(req_b[sel*9 +: 9]);
                exp_q.push_back({32'(cyc + D), 3'(sel), 20'(ma * mb)});
`ifdef DWT_MUL_ARB_PRIO0_EN
                if (sel != 0) ptr_m = (sel + 1) % N;
`else
                ptr_m = (sel + 1) % N;
`endif
            end
            chk("grant", 64'(req_ready), 64'(eg));
            re2 = re1;
            re1 = run_en;
        end
    end

    // ---------------- monitor ----------------
    logic exp_v;

    always begin
        @(negedge clk);
        #1;
        chk("idle", 64'(idle), 64'(exp_idle));
        if (!ap_rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_p", 64'(rsp_p), 64'(0));
            chk("rst_rsp_id", 64'(rsp_id), 64'(0));
            last_p  = '0;
            last_id = '0;
        end else begin
            exp_v = (exp_q.size() > 0) && (int'(exp_q[0][54:23]) == cyc);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (rsp_valid && exp_v) begin
                chk("rsp_id", 64'(rsp_id), 64'(exp_q[0][22:20]));
                chk("rsp_p", 64'(rsp_p), 64'(exp_q[0][19:0]));
                last_p  = rsp_p;
                last_id = rsp_id;
            end else if (!rsp_valid) begin
                chk("hold_p", 64'(rsp_p), 64'(last_p));
                chk("hold_id", 64'(rsp_id), 64'(last_id));
            end
            if (exp_v) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*11 +: 11] = 11'(a);
        req_b[i*9 +: 9]   = 9'(b);
    endtask

    function automatic int rnd_a();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2047;
        if (r == 1) return 0;
        return int'($urandom_range(0, 2047));
    endfunction

    function automatic int rnd_b();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 511;
        if (r == 1) return 0;
        return int'($urandom_range(0, 511));
    endfunction

    // Requesters hold valid until transferred, then may present a new pair.
    task automatic refresh(input logic [N-1:0] mask, input int pct);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || took[i]) begin
                req_valid[i] = mask[i] && (int'($urandom_range(0, 99)) < pct);
                set_op(i, rnd_a(), rnd_b());
            end
        end
    endtask

    task automatic wait_took(input int i, input int budget);
        int n;
        n = 0;
        tick();
        while (!took[i] && n < budget) begin
            tick();
            n++;
        end
        chk("grant_timeout", 64'(took[i]), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!idle && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(idle), 64'(1));
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        run_en    = 1'b0;
        req_valid = '0;
        repeat (3) tick();
        ap_rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // All four valid continuously from pointer 0: grants 0,1,2,3,0,...
        run_en = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, rnd_a(), rnd_b());
        req_valid = '1;
        repeat (12) begin
            tick();
            refresh('1, 100);
        end
        // Drop run_en with two products in flight; valids stay high.
        run_en = 1'b0;
        tick();
        wait_idle(20);
        req_valid = '0;
        tick();

        // Single requester 2 with the largest operands.
        run_en = 1'b1;
        set_op(2, 2047, 511);
        req_valid = 4'b0100;
        wait_took(2, 10);
        req_valid = '0;
        repeat (4) tick();

        // Zero product then one, back-to-back from requester 1.
        set_op(1, 0, 511);
        req_valid = 4'b0010;
        wait_took(1, 10);
        set_op(1, 1, 1);
        wait_took(1, 10);
        req_valid = '0;
        run_en = 1'b0;
        tick();
        wait_idle(20);

        // Reset with the pipeline full, then restart: pointer back at 0.
        run_en = 1'b1;
        req_valid = '1;
        repeat (6) begin
            tick();
            refresh('1, 100);
        end
        do_reset();
        run_en = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, rnd_a(), rnd_b());
        req_valid = '1;
        repeat (8) begin
            tick();
            refresh('1, 100);
        end
        run_en = 1'b0;
        req_valid = '0;
        tick();
        wait_idle(20);

`ifdef DWT_MUL_ARB_PRIO0_EN
        // Requesters 0 and 3 held: 0 wins until it drops.
        run_en = 1'b1;
        req_valid = 4'b1001;
        repeat (6) begin
            tick();
            refresh(4'b1001, 100);
        end
        req_valid[0] = 1'b0;
        repeat (3) tick();
        run_en = 1'b0;
        req_valid = '0;
        tick();
        wait_idle(20);
`endif

        // Random traffic with run_en toggling.
        for (int t = 0; t < 400; t++) begin
            run_en = ($urandom_range(0, 7) != 0);
            refresh('1, 60);
            tick();
        end
        run_en = 1'b0;
        req_valid = '0;
        tick();
        wait_idle(30);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dwt_mul_arbiter.md
DWT_MUL_ARBITER -- requirements
Module: dwt_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, number of register stages after the multiply (1..4).
REQ-003 SHALL have port ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port run_en  input  1  level-sensitive; high permits new grants.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester grant, one-hot or zero.
REQ-008 SHALL have port req_a  input  N_REQ*11  packed unsigned 11-bit operands; requester i in bits [11i+10:11i].
REQ-009 SHALL have port req_b  input  N_REQ*9  packed unsigned 9-bit operands; requester i in bits [9i+8:9i].
REQ-010 SHALL have port rsp_valid  output  1  product valid.
REQ-011 SHALL have port rsp_id  output  3  index of the requester owning the product.
REQ-012 SHALL have port rsp_p  output  20  unsigned product.
REQ-013 SHALL have port idle  output  1  high when in IDLE with the pipeline empty.

Function
REQ-014 SHALL run a controller FSM with states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN SHALL occur on the first cycle run_en=1.
REQ-016 RUN->DRAIN SHALL occur on the first cycle run_en=0.
REQ-017 DRAIN->IDLE SHALL occur when no valid remains in any pipeline stage.
REQ-018 DRAIN->RUN SHALL occur if run_en returns high before the pipeline is empty.
REQ-019 Grants SHALL issue only in RUN: at most one req_ready bit per cycle, combinationally from req_valid and the arbiter pointer.
REQ-020 Transfer SHALL occur when req_valid[i] and req_ready[i] are both high; req_ready SHALL never assert for a requester with req_valid=0.
REQ-021 Arbitration SHALL be round-robin: search starts at pointer; after a transfer from i, pointer becomes (i+1) mod N_REQ; pointer unchanged when no transfer occurs.
REQ-022 A transferred operand pair SHALL be multiplied as $unsigned(a)*$unsigned(b) into 20 bits with no truncation (max 2047*511=1046017).
REQ-023 Product, id and valid SHALL appear on rsp_* exactly PIPE_DEPTH cycles after the transfer edge; throughput one product per cycle.
REQ-024 rsp_p and rsp_id SHALL hold their previous value when rsp_valid=0.
REQ-025 There is no response back-pressure; the consumer SHALL accept every rsp_valid pulse.
REQ-026 Any requester holding req_valid high SHALL be granted within N_REQ cycles in RUN.

Reset
REQ-027 On ap_rst_n low, the block SHALL immediately enter IDLE, set pointer=0, clear all pipeline valids, and drive rsp_p=0, rsp_id=0, rsp_valid=0, req_ready=0, idle=1.
REQ-028 Reset mid-operation SHALL discard in-flight products without emitting them.
REQ-029 Deassertion SHALL be synchronous to ap_clk via a two-flop synchroniser internal to the block.

Configuration
REQ-030 With macro DWT_MUL_ARB_PRIO0_EN defined, requester 0 SHALL win whenever req_valid[0]=1; the remaining requesters SHALL be round-robin among themselves.
REQ-031 Without DWT_MUL_ARB_PRIO0_EN, all requesters SHALL be pure round-robin per REQ-021.

Structure
REQ-032 Shared package dwt_mul_pkg SHALL hold operand widths (11, 9, 20), id width (3) and the FSM state enum.
REQ-033 The round-robin grant logic SHALL be one sub-module, dwt_rr_arb, instantiated once.

Verification
REQ-034 Single requester: run_en=1, requester 2 sends a=2047, b=511 -> rsp_p=1046017, rsp_id=2, exactly PIPE_DEPTH cycles later.
REQ-035 All four valid continuously from pointer 0 -> grants 0,1,2,3,0,... one per cycle; products arrive in the same order.
REQ-036 run_en dropped with 2 products in flight -> no grants, both products emitted, then idle=1 in the cycle after the last rsp_valid.
REQ-037 ap_rst_n pulsed low with the pipeline full -> no rsp_valid until new transfers occur; pointer=0.
REQ-038 With DWT_MUL_ARB_PRIO0_EN, requesters 0 and 3 held valid -> requester 0 granted every cycle; requester 3 granted only after req_valid[0] drops.
REQ-039 Operands a=0, b=511 and a=1, b=1 back-to-back -> rsp_p=0, then rsp_p=1, on consecutive cycles.
